pipe_stall_ctrl: RTL and testbench

Central stall/flush controller for the five-stage OpenMIPS pipeline. It merges the load-use stall request from ID, a multi-cycle EX operation (divide) and an exception flush into one stall vector. Every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) uses that vector to hold or advance. It also drives the flush pulse and redirect PC that clear the pipeline registers and reload the PC.

---
 rtl/pipe_stall_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_stall_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: merges load-use, multi-cycle EX and exception flush into one pipeline stall vector.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stall_ctrl #(
    parameter int MC_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        ex_mc_start,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        mc_busy,
    output logic        mc_done,
    output logic [31:0] stall_cycles
);
    typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [5:0]  mc_cnt_q, mc_cnt_d;
    logic [31:0] new_pc_q, new_pc_d;

    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        new_pc_d = new_pc_q;
        stall    = 6'b000000;
        mc_done  = 1'b0;
        case (state_q)
            RUN: begin
                if (flush_req) begin
                    state_d  = FLUSH;
                    new_pc_d = flush_pc;
                end else if (ex_mc_start) begin
                    stall    = 6'b001111;
                    mc_cnt_d = 6'(MC_CYCLES - 1);
                    state_d  = MC_WAIT;
                end else if (stallreq_id) begin
                    stall = 6'b000111;
                end
            end
            MC_WAIT: begin
                if (flush_req) begin
                    state_d  = FLUSH;
                    new_pc_d = flush_pc;
                end else if (mc_cnt_q != 6'd0) begin
                    stall    = 6'b001111;
                    mc_cnt_d = mc_cnt_q - 6'd1;
                end else begin
                    mc_done = 1'b1;
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (flush_req) new_pc_d = flush_pc;
                else state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        // reset dominates the combinational outputs as well as the state
        if (rst) begin
            stall   = 6'b000000;
            mc_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            mc_cnt_q <= 6'd0;
            new_pc_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign flush   = (state_q == FLUSH);
    assign new_pc  = new_pc_q;
    assign mc_busy = (state_q == MC_WAIT);

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = (stall[0] && stall_cycles_q != 32'hFFFF_FFFF) ? stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cycles_q <= 32'h0;
        else stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed bench with a cycle-timeline reference model and hand-computed checks.
module tb_pipe_stall_ctrl;
    localparam int MC = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_id = 1'b0, ex_mc_start = 1'b0, flush_req = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [5:0]  stall;
    logic        flush, mc_busy, mc_done;
    logic [31:0] new_pc, stall_cycles;

    int n_chk = 0, n_fail = 0;

    pipe_stall_ctrl #(.MC_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
        .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall), .flush(flush),
        .new_pc(new_pc), .mc_busy(mc_busy), .mc_done(mc_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: multi-cycle op is a start cycle plus an age, flush is a one-cycle echo of flush_req.
    int          cyc = 0, m_t = 0;
    bit          m_mc = 0, m_fl = 0;
    logic [31:0] m_pc = 32'h0, m_cnt = 32'h0;
    logic [5:0]  es_r = 6'h0;

    always @(negedge clk) begin
        int age;
        logic [5:0] es;
        bit ed;
        age = cyc - m_t;
        if (rst || m_fl) es = 6'h00;
        else if (m_mc) es = (flush_req || age >= MC) ? 6'h00 : 6'h0F;
        else es = flush_req ? 6'h00 : ex_mc_start ? 6'h0F : stallreq_id ? 6'h07 : 6'h00;
        ed = !rst && m_mc && !flush_req && age == MC;
        es_r = es;
        chk("m_stall", {26'h0, stall}, {26'h0, es});
        chk("m_mc_done", {31'h0, mc_done}, {31'h0, ed});
        chk("m_mc_busy", {31'h0, mc_busy}, {31'h0, m_mc});
        chk("m_flush", {31'h0, flush}, {31'h0, m_fl});
        if (m_fl) chk("m_new_pc", new_pc, m_pc);
`ifdef PIPE_STALL_CNT_EN
        chk("m_stall_cycles", stall_cycles, m_cnt);
`else
        chk("m_stall_cycles", stall_cycles, 32'h0);
`endif
    end

    always @(posedge clk) begin
        bit fl0;
        int age;
        fl0 = m_fl;
        age = cyc - m_t;
        if (rst) begin
            m_mc = 0; m_fl = 0; m_pc = 32'h0; m_cnt = 32'h0;
        end else begin
            if (es_r[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (flush_req) begin
                m_fl = 1; m_pc = flush_pc; m_mc = 0;
            end else begin
                m_fl = 0;
                if (m_mc) begin
                    if (age == MC) m_mc = 0;
                end else if (!fl0 && ex_mc_start) begin
                    m_mc = 1; m_t = cyc;
                end
            end
        end
        cyc++;
    end

    task automatic step(input logic r, input logic s, input logic m, input logic f, input logic [31:0] pc);
        @(posedge clk);
        #1;
        rst = r; stallreq_id = s; ex_mc_start = m; flush_req = f; flush_pc = pc;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        int nst, nbusy, done_at, ndone;
        logic [31:0] sc0;
        // reset with random inputs
        for (int i = 0; i < 2; i++) step(1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
        chk("rst_stall", {26'h0, stall}, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_busy", {31'h0, mc_busy}, 32'h0);
        chk("rst_cnt", stall_cycles, 32'h0);
        idle(1);
        // load-use
        step(0, 1, 0, 0, 32'h0);
        chk("lu_stall", {26'h0, stall}, 32'h07);
        step(0, 0, 0, 0, 32'h0);
        chk("lu_stall_next", {26'h0, stall}, 32'h00);
        chk("lu_busy", {31'h0, mc_busy}, 32'h0);
        chk("lu_flush", {31'h0, flush}, 32'h0);
        // divide
        sc0 = stall_cycles;
        nst = 0; nbusy = 0; done_at = -1; ndone = 0;
        step(0, 1, 1, 0, 32'h0);
        if (stall == 6'h0F) nst++;
        for (int i = 1; i <= MC + 1; i++) begin
            step(0, 0, 0, 0, 32'h0);
            if (stall == 6'h0F) nst++;
            if (mc_busy) nbusy++;
            if (mc_done) begin ndone++; done_at = i; end
        end
        chk("div_stall_cycles", nst, MC);
        chk("div_busy_cycles", nbusy, MC);
        chk("div_done_at", done_at, MC);
        chk("div_done_count", ndone, 1);
`ifdef PIPE_STALL_CNT_EN
        chk("div_cnt_delta", stall_cycles - sc0, MC);
`else
        chk("div_cnt_delta", stall_cycles - sc0, 0);
`endif
        // abort at 5th MC_WAIT cycle
        step(0, 0, 1, 0, 32'h0);
        idle(4);
        step(0, 0, 0, 1, 32'h0000_0180);
        chk("ab_stall", {26'h0, stall}, 32'h0);
        chk("ab_done", {31'h0, mc_done}, 32'h0);
        ndone = 0;
        step(0, 0, 0, 0, 32'h0);
        chk("ab_flush", {31'h0, flush}, 32'h1);
        chk("ab_new_pc", new_pc, 32'h0000_0180);
        for (int i = 0; i < MC + 4; i++) begin
            step(0, 0, 0, 0, 32'h0);
            if (mc_done || mc_busy) ndone++;
        end
        chk("ab_no_done", ndone, 0);
        // priority
        step(0, 1, 1, 1, 32'h0000_0040);
        chk("pri_stall", {26'h0, stall}, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("pri_flush", {31'h0, flush}, 32'h1);
        chk("pri_busy", {31'h0, mc_busy}, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("pri_busy2", {31'h0, mc_busy}, 32'h0);
        chk("pri_flush2", {31'h0, flush}, 32'h0);
        // back-to-back flush
        step(0, 0, 0, 1, 32'h0000_0180);
        step(0, 1, 1, 1, 32'h0000_0200);
        chk("bb_flush1", {31'h0, flush}, 32'h1);
        chk("bb_pc1", new_pc, 32'h0000_0180);
        chk("bb_stall_in_flush", {26'h0, stall}, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("bb_flush2", {31'h0, flush}, 32'h1);
        chk("bb_pc2", new_pc, 32'h0000_0200);
        step(0, 0, 0, 0, 32'h0);
        chk("bb_flush3", {31'h0, flush}, 32'h0);
        // reset inside MC_WAIT and inside FLUSH
        step(0, 0, 1, 0, 32'h0);
        idle(3);
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("rmc_busy", {31'h0, mc_busy}, 32'h0);
        chk("rmc_done", {31'h0, mc_done}, 32'h0);
        step(0, 0, 0, 1, 32'h0000_0300);
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("rfl_flush", {31'h0, flush}, 32'h0);
        chk("rfl_new_pc", new_pc, 32'h0);
        // random mix, checked by the model only
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 24) == 0, $urandom);
        idle(MC + 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
